// File: rtl/sync_filter_chan.sv
// One channel: synchronizer chain, stability counter, edge/glitch pulse registers.
// Latency: STAGES cycles to sync, plus FILTER_LEN cycles of stability before out moves.
// Backpressure: none; a free-running level path that samples every cycle.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : asynchronous level input
//   out        : synchronized, deglitched level
//   rise/fall  : one-cycle pulse on the edge out changes 0->1 / 1->0
//   glitch     : one-cycle pulse when a pending change is abandoned
module sync_filter_chan #(
  parameter int   STAGES     = 2,
  parameter int   FILTER_LEN = 1,
  parameter logic RESET_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int              CW   = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]   LAST = CW'(FILTER_LEN - 1);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt;
  logic              s;

  // sync_q[0] is the metastability-exposed flop; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_BIT}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in};
    end
  end

  assign s = sync_q[STAGES-1];

  // The counter tracks how long s has disagreed with out. It stops at LAST
  // because reaching LAST with s still different commits the change and
  // clears it on the same edge, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      out    <= RESET_BIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      if (s == out) begin
        // s came back before qualifying: an abandoned change if we had counted.
        cnt    <= '0;
        glitch <= (cnt != '0);
      end else if (cnt == LAST) begin
        // Commit. A toggle of s after this edge restarts the count from 0.
        out  <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_filter_edge.sv
// WIDTH independent synchronize + deglitch + edge-detect channels.
// Latency: STAGES + FILTER_LEN cycles from a settled input edge to out.
// Backpressure: none; every channel samples every cycle.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (release is expected synchronous)
//   in         : WIDTH asynchronous level inputs
//   out        : WIDTH synchronized, deglitched levels (reset to RESET_VAL)
//   rise/fall  : WIDTH one-cycle pulses on out 0->1 / 1->0
//   glitch     : WIDTH one-cycle pulses on abandoned pending changes
module sync_filter_edge #(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch
);

  // Reject illegal configurations at elaboration.
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_filter_edge: STAGES must be in 2..4");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 65535) begin : g_bad_filter_len
    $error("sync_filter_edge: FILTER_LEN must be in 1..65535");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_BIT  (RESET_VAL[i])
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in[i]),
      .out    (out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .glitch (glitch[i])
    );
  end

endmodule

// File: doc/sync_filter_edge.md
SYNC_FILTER_EDGE -- requirements
Module: sync_filter_edge

Interface
REQ-001 Parameter WIDTH, default 1: number of independent asynchronous channels.
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per channel; legal range 2..4.
REQ-003 Parameter FILTER_LEN, default 1: consecutive stable cycles required before the filtered level changes; legal range 1..65535.
REQ-004 Parameter RESET_VAL, default all zeros, WIDTH bits: reset level of the synchronizer chain and the filtered output per channel.
REQ-005 Port clk, input, 1: single clock; all state is on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port in, input, WIDTH: asynchronous level inputs.
REQ-008 Port out, output, WIDTH: synchronized, deglitched level.
REQ-009 Port rise, output, WIDTH: one-cycle pulse when out goes 0->1.
REQ-010 Port fall, output, WIDTH: one-cycle pulse when out goes 1->0.
REQ-011 Port glitch, output, WIDTH: one-cycle pulse when a pending change is abandoned before qualification.

Function
REQ-012 Each channel SHALL pass in[i] through STAGES flops; the last flop is the sync value s[i]; there is no combinational path from in to any output.
REQ-013 Each channel SHALL hold a counter of width clog2(FILTER_LEN+1), saturating, never wrapping.
REQ-014 While s[i]==out[i], the counter SHALL be 0 the next cycle.
REQ-015 While s[i]!=out[i] and counter < FILTER_LEN-1, the counter SHALL increment by 1.
REQ-016 While s[i]!=out[i] and counter == FILTER_LEN-1, out[i] SHALL take s[i] and the counter SHALL clear, all on the same edge.
REQ-017 With FILTER_LEN=1, out[i] SHALL follow s[i] one cycle later and glitch SHALL never assert.
REQ-018 Latency: a clean in[i] edge settled before clock edge 1 SHALL appear on out[i] after edge STAGES+FILTER_LEN.
REQ-019 rise[i]/fall[i] SHALL be registered, asserting on the same edge out[i] changes, for exactly one cycle; rise and fall are never simultaneously high on one channel.
REQ-020 glitch[i] SHALL pulse for one cycle on the edge where the counter goes nonzero->0 without an out[i] change (s[i] returned to out[i]).
REQ-021 A toggle on s[i] occurring exactly at qualification SHALL NOT abort the update; the toggle starts a new count from 0 on the following cycle.
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels have no interaction.
REQ-023 Back-to-back changes: after an update, a further change SHALL need another full FILTER_LEN cycles to qualify.

Reset
REQ-024 On rst_n low, all sync flops and out SHALL be RESET_VAL, counters 0, rise/fall/glitch 0, asynchronously.
REQ-025 Reset release SHALL be treated as synchronous to clk by the instantiating logic; no edge pulse SHALL be generated by release itself, even if in differs from RESET_VAL (that difference qualifies normally).
REQ-026 Reset mid-count SHALL discard the pending change with no glitch pulse.

Structure
REQ-027 No shared package; all constants are module parameters; counter width is derived locally via $clog2.
REQ-028 One sub-module, sync_filter_chan, SHALL implement one channel (chain, counter, edge/glitch registers); the top instantiates it WIDTH times in a generate loop.
REQ-029 Illegal STAGES or FILTER_LEN SHALL fail elaboration.

Verification
REQ-030 WIDTH=1, STAGES=2, FILTER_LEN=1: in 0->1 before edge 1 -> out high after edge 3, rise pulses on edge 3 only.
REQ-031 STAGES=3, FILTER_LEN=4: in high for 3 cycles then low -> out stays 0, glitch pulses once, no rise.
REQ-032 STAGES=3, FILTER_LEN=4: in held high -> out rises after edge 7; then held low -> fall exactly 7 cycles after the in change.
REQ-033 WIDTH=4, RESET_VAL=4'b1010, in=4'b0101 during reset -> after release out=4'b1010 with no pulses, then out=4'b0101 after STAGES+FILTER_LEN cycles with rise=4'b0101 and fall=4'b1010 on that edge.
REQ-034 FILTER_LEN=65535: counter saturates at 65534 then updates; no wrap; rst_n asserted at count 30000 -> counter 0, no glitch.
REQ-035 Random async toggling on all channels vs. a cycle-accurate model -> out, rise, fall, glitch match every cycle.
